// File: rtl/mapper_001.sv
// MMC1-compatible cartridge mapper: 5-bit serial load port feeding ctrl/chr0/chr1/prg
// registers, which drive PRG/CHR/PRG-RAM banking, chip selects and nametable mirroring.
module mapper_001 #(
   parameter int PRG_ROM_DEPTH = 18,
   parameter int CHR_ROM_DEPTH = 17,
   parameter int PRG_RAM_DEPTH = 13
) (
   input  logic                     clk_cpu,
   input  logic                     rst,
   input  logic [14:0]              cpu_addr,
   input  logic [7:0]               cpu_data_i,
   input  logic [13:0]              ppu_addr,
   input  logic                     cpu_rw,
   input  logic                     romsel,
   input  logic                     mirrorv,
   input  logic                     chr_ram,
   input  logic                     prg_ram,
   input  logic [PRG_ROM_DEPTH-1:0] prg_mask,
   input  logic [CHR_ROM_DEPTH-1:0] chr_mask,
   input  logic [PRG_RAM_DEPTH-1:0] prgram_mask,
   output logic [PRG_ROM_DEPTH-1:0] prg_addr,
   output logic [CHR_ROM_DEPTH-1:0] chr_addr,
   output logic [PRG_RAM_DEPTH-1:0] prgram_addr,
   output logic                     prg_cs,
   output logic                     chr_cs,
   output logic                     prgram_cs,
   output logic [7:0]               mapper_reg_o,
   output logic                     ciram_ce,
   output logic                     ciram_a10,
   output logic                     irq
);

   localparam logic [4:0] CTRL_RST  = 5'h0C;
   localparam logic [4:0] SHIFT_RST = 5'b10000;

   logic [4:0] ctrl_q, ctrl_d;
   logic [4:0] chr0_q, chr0_d;
   logic [4:0] chr1_q, chr1_d;
   logic [4:0] prg_q, prg_d;
   logic [4:0] shift_q, shift_d;
   logic       prev_wr_q, prev_wr_d;

   logic       wr, acc;
   logic [4:0] load_val;
   logic [3:0] b16;
   logic [4:0] b4;

   logic [PRG_ROM_DEPTH+17:0] prg_ext;
   logic [CHR_ROM_DEPTH+16:0] chr_ext;
   logic [PRG_RAM_DEPTH+12:0] prgram_ext;

   // Header mirroring and CHR-RAM flag do not affect MMC1 banking.
   logic unused_ok;
   assign unused_ok = &{1'b0, mirrorv, chr_ram, cpu_data_i[6:1]};

   // Only the first cycle of a run of write cycles is accepted (RMW double writes).
   assign wr       = romsel & ~cpu_rw;
   assign acc      = wr & ~prev_wr_q;
   assign load_val = {cpu_data_i[0], shift_q[4:1]};

   always_comb begin
      ctrl_d    = ctrl_q;
      chr0_d    = chr0_q;
      chr1_d    = chr1_q;
      prg_d     = prg_q;
      shift_d   = shift_q;
      prev_wr_d = wr;
      if (acc) begin
         if (cpu_data_i[7]) begin
            shift_d = SHIFT_RST;
            ctrl_d  = ctrl_q | CTRL_RST;
         end else if (!shift_q[0]) begin
            shift_d = load_val;
         end else begin
            // Marker bit reached bit 0: this is the fifth write, its address picks the target.
            shift_d = SHIFT_RST;
            unique case (cpu_addr[14:13])
               2'b00: ctrl_d = load_val;
               2'b01: chr0_d = load_val;
               2'b10: chr1_d = load_val;
               2'b11: prg_d  = load_val;
            endcase
         end
      end
   end

   always_ff @(posedge clk_cpu) begin
      if (rst) begin
         ctrl_q    <= CTRL_RST;
         chr0_q    <= 5'h00;
         chr1_q    <= 5'h00;
         prg_q     <= 5'h00;
         shift_q   <= SHIFT_RST;
         prev_wr_q <= 1'b0;
      end else begin
         ctrl_q    <= ctrl_d;
         chr0_q    <= chr0_d;
         chr1_q    <= chr1_d;
         prg_q     <= prg_d;
         shift_q   <= shift_d;
         prev_wr_q <= prev_wr_d;
      end
   end

   // PRG banking: 32 KB mode, or 16 KB with first/last half fixed.
   always_comb begin
      b16 = {prg_q[3:1], cpu_addr[14]};
      unique case (ctrl_q[3:2])
         2'b00, 2'b01: b16 = {prg_q[3:1], cpu_addr[14]};
         2'b10:        b16 = cpu_addr[14] ? prg_q[3:0] : 4'h0;
         2'b11:        b16 = cpu_addr[14] ? 4'hF : prg_q[3:0];
      endcase
   end

   always_comb begin
      if (ctrl_q[4]) b4 = ppu_addr[12] ? chr1_q : chr0_q;
      else           b4 = {chr0_q[4:1], ppu_addr[12]};
   end

   always_comb begin
      unique case (ctrl_q[1:0])
         2'b00: ciram_a10 = 1'b0;
         2'b01: ciram_a10 = 1'b1;
         2'b10: ciram_a10 = ppu_addr[10];
         2'b11: ciram_a10 = ppu_addr[11];
      endcase
   end

   assign prg_ext    = {{PRG_ROM_DEPTH{1'b0}}, b16, cpu_addr[13:0]};
   assign chr_ext    = {{CHR_ROM_DEPTH{1'b0}}, b4, ppu_addr[11:0]};
   assign prgram_ext = {{PRG_RAM_DEPTH{1'b0}}, cpu_addr[12:0]};

   assign prg_addr     = prg_mask & prg_ext[PRG_ROM_DEPTH-1:0];
   assign chr_addr     = chr_mask & chr_ext[CHR_ROM_DEPTH-1:0];
   assign prgram_addr  = prgram_mask & prgram_ext[PRG_RAM_DEPTH-1:0];
   assign prg_cs       = romsel;
   assign ciram_ce     = ppu_addr[13];
   assign chr_cs       = ~ppu_addr[13];
   assign prgram_cs    = prg_ram & ~romsel & (cpu_addr[14:13] == 2'b11) & ~prg_q[4];
   assign mapper_reg_o = {3'b000, ctrl_q};
   assign irq          = 1'b0;

endmodule

// File: tb/tb_mapper_001.sv
// Directed bench for mapper_001: serial loading, reset bit, RMW filtering, banking,
// mirroring, PRG RAM select and mid-sequence reset.
module tb_mapper_001;

   logic        clk_cpu = 1'b0;
   logic        rst;
   logic [14:0] cpu_addr;
   logic [7:0]  cpu_data_i;
   logic [13:0] ppu_addr;
   logic        cpu_rw, romsel, mirrorv, chr_ram, prg_ram;
   logic [17:0] prg_mask;
   logic [16:0] chr_mask;
   logic [12:0] prgram_mask;
   logic [17:0] prg_addr;
   logic [16:0] chr_addr;
   logic [12:0] prgram_addr;
   logic        prg_cs, chr_cs, prgram_cs, ciram_ce, ciram_a10, irq;
   logic [7:0]  mapper_reg_o;

   int vec = 0;
   int err = 0;

   mapper_001 dut (
      .clk_cpu(clk_cpu), .rst(rst), .cpu_addr(cpu_addr), .cpu_data_i(cpu_data_i),
      .ppu_addr(ppu_addr), .cpu_rw(cpu_rw), .romsel(romsel), .mirrorv(mirrorv),
      .chr_ram(chr_ram), .prg_ram(prg_ram), .prg_mask(prg_mask), .chr_mask(chr_mask),
      .prgram_mask(prgram_mask), .prg_addr(prg_addr), .chr_addr(chr_addr),
      .prgram_addr(prgram_addr), .prg_cs(prg_cs), .chr_cs(chr_cs), .prgram_cs(prgram_cs),
      .mapper_reg_o(mapper_reg_o), .ciram_ce(ciram_ce), .ciram_a10(ciram_a10), .irq(irq)
   );

   always #5 clk_cpu = ~clk_cpu;

   // Isolated ROM write: one write cycle followed by one idle cycle.
   task automatic bus_write(input logic [14:0] a, input logic [7:0] d);
      @(negedge clk_cpu);
      romsel = 1'b1; cpu_rw = 1'b0; cpu_addr = a; cpu_data_i = d;
      @(negedge clk_cpu);
      romsel = 1'b0; cpu_rw = 1'b1;
      @(negedge clk_cpu);
   endtask

   task automatic load_reg(input logic [14:0] a, input logic [4:0] v);
      for (int i = 0; i < 5; i++) bus_write(a, {7'b0, v[i]});
   endtask

   task automatic cpu_read(input logic [14:0] a, input logic rs);
      @(negedge clk_cpu);
      romsel = rs; cpu_rw = 1'b1; cpu_addr = a;
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      @(negedge clk_cpu); @(negedge clk_cpu);
      rst = 1'b0;
      cpu_read(15'h4000, 1'b1);
      vec++; if (prg_addr !== 18'h3C000) begin err++; $display("FAIL reset_prg_hi got %h exp %h", prg_addr, 18'h3C000); end
      vec++; if (mapper_reg_o !== 8'h0C) begin err++; $display("FAIL reset_ctrl got %h exp %h", mapper_reg_o, 8'h0C); end
      vec++; if (prg_cs !== 1'b1 || irq !== 1'b0) begin err++; $display("FAIL reset_cs_irq got %b%b exp 10", prg_cs, irq); end
      cpu_read(15'h0000, 1'b1);
      vec++; if (prg_addr !== 18'h00000) begin err++; $display("FAIL reset_prg_lo got %h exp %h", prg_addr, 18'h0); end
   endtask

   task automatic test_prg_modes;
      load_reg(15'h6000, 5'b00101);
      cpu_read(15'h0000, 1'b1);
      vec++; if (prg_addr !== 18'h14000) begin err++; $display("FAIL mode3_lo got %h exp %h", prg_addr, 18'h14000); end
      cpu_read(15'h4000, 1'b1);
      vec++; if (prg_addr !== 18'h3C000) begin err++; $display("FAIL mode3_hi got %h exp %h", prg_addr, 18'h3C000); end
      load_reg(15'h0000, 5'h08);
      cpu_read(15'h0000, 1'b1);
      vec++; if (prg_addr !== 18'h00000) begin err++; $display("FAIL mode2_lo got %h exp %h", prg_addr, 18'h0); end
      cpu_read(15'h4000, 1'b1);
      vec++; if (prg_addr !== 18'h14000) begin err++; $display("FAIL mode2_hi got %h exp %h", prg_addr, 18'h14000); end
      load_reg(15'h0000, 5'h00);
      cpu_read(15'h0000, 1'b1);
      vec++; if (prg_addr !== 18'h10000) begin err++; $display("FAIL mode0_lo got %h exp %h", prg_addr, 18'h10000); end
      cpu_read(15'h4123, 1'b1);
      vec++; if (prg_addr !== 18'h14123) begin err++; $display("FAIL mode0_hi got %h exp %h", prg_addr, 18'h14123); end
      vec++; if (mapper_reg_o !== 8'h00) begin err++; $display("FAIL mode0_ctrl got %h exp %h", mapper_reg_o, 8'h00); end
   endtask

   task automatic test_reset_bit;
      bus_write(15'h0000, 8'h01);
      bus_write(15'h0000, 8'h01);
      bus_write(15'h0000, 8'h80);
      vec++; if (mapper_reg_o !== 8'h0C) begin err++; $display("FAIL rbit_ctrl got %h exp %h", mapper_reg_o, 8'h0C); end
      bus_write(15'h0000, 8'h01);
      bus_write(15'h0000, 8'h01);
      bus_write(15'h0000, 8'h00);
      bus_write(15'h0000, 8'h00);
      vec++; if (mapper_reg_o !== 8'h0C) begin err++; $display("FAIL rbit_early got %h exp %h", mapper_reg_o, 8'h0C); end
      bus_write(15'h0000, 8'h01);
      vec++; if (mapper_reg_o !== 8'h13) begin err++; $display("FAIL rbit_reload got %h exp %h", mapper_reg_o, 8'h13); end
      bus_write(15'h0000, 8'h80);
      vec++; if (mapper_reg_o !== 8'h1F) begin err++; $display("FAIL rbit_or got %h exp %h", mapper_reg_o, 8'h1F); end
   endtask

   // Each bit is written twice on consecutive cycles; the second copy carries the wrong bit.
   task automatic test_back_to_back;
      logic [4:0] v;
      v = 5'b01010;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_cpu);
         romsel = 1'b1; cpu_rw = 1'b0; cpu_addr = 15'h6000; cpu_data_i = {7'b0, v[i]};
         @(negedge clk_cpu);
         cpu_data_i = {7'b0, ~v[i]};
         @(negedge clk_cpu);
         romsel = 1'b0; cpu_rw = 1'b1;
         if (i == 3) begin
            cpu_read(15'h0000, 1'b1);
            vec++; if (prg_addr !== 18'h14000) begin err++; $display("FAIL rmw_early got %h exp %h", prg_addr, 18'h14000); end
            romsel = 1'b0;
         end
      end
      cpu_read(15'h0000, 1'b1);
      vec++; if (prg_addr !== 18'h28000) begin err++; $display("FAIL rmw_load got %h exp %h", prg_addr, 18'h28000); end
      vec++; if (mapper_reg_o !== 8'h1F) begin err++; $display("FAIL rmw_ctrl got %h exp %h", mapper_reg_o, 8'h1F); end
   endtask

   task automatic test_chr;
      load_reg(15'h0000, 5'h10);
      load_reg(15'h2000, 5'h03);
      load_reg(15'h4000, 5'h07);
      ppu_addr = 14'h1234; #1;
      vec++; if (chr_addr !== 17'h07234) begin err++; $display("FAIL chr4k_hi got %h exp %h", chr_addr, 17'h07234); end
      vec++; if (chr_cs !== 1'b1 || ciram_ce !== 1'b0) begin err++; $display("FAIL chr_cs got %b%b exp 10", chr_cs, ciram_ce); end
      ppu_addr = 14'h0234; #1;
      vec++; if (chr_addr !== 17'h03234) begin err++; $display("FAIL chr4k_lo got %h exp %h", chr_addr, 17'h03234); end
      load_reg(15'h0000, 5'h00);
      ppu_addr = 14'h1234; #1;
      vec++; if (chr_addr !== 17'h03234) begin err++; $display("FAIL chr8k_hi got %h exp %h", chr_addr, 17'h03234); end
      ppu_addr = 14'h0234; #1;
      vec++; if (chr_addr !== 17'h02234) begin err++; $display("FAIL chr8k_lo got %h exp %h", chr_addr, 17'h02234); end
   endtask

   task automatic test_mirror_prgram;
      load_reg(15'h0000, 5'h03);
      ppu_addr = 14'h2C00; #1;
      vec++; if (ciram_ce !== 1'b1 || ciram_a10 !== 1'b1 || chr_cs !== 1'b0) begin err++; $display("FAIL mirh_2C00 got %b%b%b exp 110", ciram_ce, ciram_a10, chr_cs); end
      ppu_addr = 14'h2400; #1;
      vec++; if (ciram_a10 !== 1'b0) begin err++; $display("FAIL mirh_2400 got %b exp 0", ciram_a10); end
      load_reg(15'h0000, 5'h02);
      ppu_addr = 14'h2400; #1;
      vec++; if (ciram_a10 !== 1'b1) begin err++; $display("FAIL mirv_2400 got %b exp 1", ciram_a10); end
      ppu_addr = 14'h2800; #1;
      vec++; if (ciram_a10 !== 1'b0) begin err++; $display("FAIL mirv_2800 got %b exp 0", ciram_a10); end
      load_reg(15'h0000, 5'h01);
      ppu_addr = 14'h2000; #1;
      vec++; if (ciram_a10 !== 1'b1) begin err++; $display("FAIL mir1 got %b exp 1", ciram_a10); end
      load_reg(15'h0000, 5'h00);
      ppu_addr = 14'h2C00; #1;
      vec++; if (ciram_a10 !== 1'b0) begin err++; $display("FAIL mir0 got %b exp 0", ciram_a10); end
      cpu_read(15'h6123, 1'b0);
      vec++; if (prgram_cs !== 1'b1) begin err++; $display("FAIL pram_cs_en got %b exp 1", prgram_cs); end
      vec++; if (prgram_addr !== 13'h0123) begin err++; $display("FAIL pram_addr got %h exp %h", prgram_addr, 13'h0123); end
      cpu_read(15'h4123, 1'b0);
      vec++; if (prgram_cs !== 1'b0) begin err++; $display("FAIL pram_cs_range got %b exp 0", prgram_cs); end
      // Load prg=0x10 with PRG RAM writes interleaved; they must not disturb the shifter.
      for (int i = 0; i < 5; i++) begin
         bus_write(15'h6000, (i == 4) ? 8'h01 : 8'h00);
         @(negedge clk_cpu);
         romsel = 1'b0; cpu_rw = 1'b0; cpu_addr = 15'h6000; cpu_data_i = 8'h01;
         @(negedge clk_cpu);
         cpu_rw = 1'b1;
      end
      cpu_read(15'h6123, 1'b0);
      vec++; if (prgram_cs !== 1'b0) begin err++; $display("FAIL pram_cs_dis got %b exp 0", prgram_cs); end
      vec++; if (mapper_reg_o !== 8'h00) begin err++; $display("FAIL pram_ctrl got %h exp %h", mapper_reg_o, 8'h00); end
   endtask

   task automatic test_mid_reset;
      bus_write(15'h0000, 8'h01);
      bus_write(15'h0000, 8'h01);
      bus_write(15'h0000, 8'h01);
      @(negedge clk_cpu); rst = 1'b1;
      @(negedge clk_cpu); rst = 1'b0;
      cpu_read(15'h0000, 1'b1);
      vec++; if (mapper_reg_o !== 8'h0C) begin err++; $display("FAIL mrst_ctrl got %h exp %h", mapper_reg_o, 8'h0C); end
      vec++; if (prg_addr !== 18'h00000) begin err++; $display("FAIL mrst_prg got %h exp %h", prg_addr, 18'h0); end
      romsel = 1'b0;
      for (int i = 0; i < 4; i++) bus_write(15'h0000, (i == 0) ? 8'h01 : 8'h00);
      vec++; if (mapper_reg_o !== 8'h0C) begin err++; $display("FAIL mrst_early got %h exp %h", mapper_reg_o, 8'h0C); end
      bus_write(15'h0000, 8'h00);
      vec++; if (mapper_reg_o !== 8'h01) begin err++; $display("FAIL mrst_load got %h exp %h", mapper_reg_o, 8'h01); end
   endtask

   initial begin
      rst = 1'b1; cpu_addr = '0; cpu_data_i = '0; ppu_addr = '0;
      cpu_rw = 1'b1; romsel = 1'b0; mirrorv = 1'b0; chr_ram = 1'b0; prg_ram = 1'b1;
      prg_mask = 18'h3FFFF; chr_mask = 17'h1FFFF; prgram_mask = 13'h1FFF;
      test_reset;
      test_prg_modes;
      test_reset_bit;
      test_back_to_back;
      test_chr;
      test_mirror_prgram;
      test_mid_reset;
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule

// File: doc/mapper_001.md
Name: mapper_001

Overview:
MMC1-compatible cartridge mapper controller. It decodes CPU writes to $8000-$FFFF through a 5-bit serial load port and sequences them into four internal bank/control registers. From those registers it generates banked PRG ROM, CHR ROM/RAM and PRG RAM addresses, chip selects and nametable mirroring. It is a drop-in alternative to the NROM mapper in the cartridge wrapper, with an identical port set.

Parameters:
PRG_ROM_DEPTH, 18, PRG ROM address width (256 KB max, sixteen 16 KB banks)
CHR_ROM_DEPTH, 17, CHR address width (128 KB max, thirty-two 4 KB banks)
PRG_RAM_DEPTH, 13, PRG RAM address width (8 KB)

Ports:
clk_cpu  in  1  CPU clock; one bus cycle per clock
rst  in  1  synchronous reset, active-high
cpu_addr  in  15  CPU address A14..A0
cpu_data_i  in  8  CPU write data
ppu_addr  in  14  PPU address
cpu_rw  in  1  1=read, 0=write
romsel  in  1  high for $8000-$FFFF accesses
mirrorv  in  1  header mirroring; unused (mirroring comes from the control register)
chr_ram  in  1  CHR is RAM; bank logic is unchanged
prg_ram  in  1  cartridge has PRG RAM
prg_mask  in  PRG_ROM_DEPTH  PRG size mask
chr_mask  in  CHR_ROM_DEPTH  CHR size mask
prgram_mask  in  PRG_RAM_DEPTH  PRG RAM size mask
prg_addr  out  PRG_ROM_DEPTH  banked PRG ROM address
chr_addr  out  CHR_ROM_DEPTH  banked CHR address
prgram_addr  out  PRG_RAM_DEPTH  PRG RAM address
prg_cs  out  1  PRG ROM select
chr_cs  out  1  CHR select
prgram_cs  out  1  PRG RAM select
mapper_reg_o  out  8  {3'b0, ctrl[4:0]}
ciram_ce  out  1  nametable (CIRAM) select
ciram_a10  out  1  CIRAM A10
irq  out  1  constant 0

Behaviour:
- Clock and reset: single clock clk_cpu; rst is synchronous, active-high.
- Reset values: ctrl=5'h0C, chr0=0, chr1=0, prg=0, shift=5'b10000, prev_wr=0. Outputs follow from these registers combinationally.
- Write strobe: wr = romsel & ~cpu_rw.
- Accepted write: acc = wr & ~prev_wr; prev_wr <= wr every cycle.
  - Back-to-back write cycles (RMW double write): only the first is accepted.
  - A write following any non-write cycle is accepted.
- On acc with cpu_data_i[7]=1: shift <= 5'b10000; ctrl <= ctrl | 5'h0C. Other registers unchanged.
- On acc with cpu_data_i[7]=0:
  - If shift[0]=0: shift <= {cpu_data_i[0], shift[4:1]}.
  - If shift[0]=1 (5th write): val = {cpu_data_i[0], shift[4:1]}; shift <= 5'b10000. Target register by cpu_addr[14:13]: 00 ctrl, 01 chr0, 10 chr1, 11 prg.
  - Only the address of the 5th write selects the target.
- Latency: a register update is visible on outputs starting the cycle after the accepted 5th write.
- ctrl fields: [1:0] mirroring, [3:2] PRG mode, [4] CHR mode. prg[3:0] is the bank; prg[4]=1 disables PRG RAM.
- PRG bank b16 (4 bits), selected by A14=cpu_addr[14]:
  - Mode 0/1: b16 = {prg[3:1], A14}.
  - Mode 2: A14=0 gives 0; A14=1 gives prg[3:0].
  - Mode 3: A14=0 gives prg[3:0]; A14=1 gives 4'hF.
- prg_addr = prg_mask & {b16, cpu_addr[13:0]}, zero-extended/truncated to PRG_ROM_DEPTH. The fixed last bank resolves via prg_mask.
- prg_cs = romsel.
- CHR bank b4 (5 bits):
  - ctrl[4]=0: b4 = {chr0[4:1], ppu_addr[12]}.
  - ctrl[4]=1: b4 = ppu_addr[12] ? chr1 : chr0.
- chr_addr = chr_mask & {b4, ppu_addr[11:0]}.
- ciram_ce = ppu_addr[13]; chr_cs = ~ciram_ce.
- ciram_a10 by mirroring: 0 gives 0, 1 gives 1, 2 gives ppu_addr[10] (vertical), 3 gives ppu_addr[11] (horizontal).
- prgram_cs = prg_ram & ~romsel & cpu_addr[14:13]==2'b11 & ~prg[4].
- prgram_addr = prgram_mask & cpu_addr[12:0].
- PRG RAM accesses never touch shift or prev_wr.
- rst asserted mid-sequence: all state returns to reset values the next edge, and the partial shift is discarded.

Test Plan:
- Reset, then CPU read at cpu_addr=15'h4000 with romsel=1 -> ctrl=5'h0C and b16=4'hF; prg_addr=18'h3C000 & prg_mask; mapper_reg_o=8'h0C.
- Five isolated writes to $E000 with d0 sequence 1,0,1,0,0 -> prg=5'b00101; read at $8000 gives prg_addr=18'h14000 one cycle later.
- Two writes of bit 1 to $8000, then a write with cpu_data_i=8'h80 -> shift=5'b10000, ctrl unchanged except [3:2]=11; a following full 5-write sequence loads normally.
- Writes on consecutive cycles (RMW pair) -> only the first shifts in; five accepted writes are needed before the register loads.
- ctrl=5'h10, chr0=5'h03, chr1=5'h07, ppu_addr=14'h1234 -> chr_addr=17'h07234. With ctrl=5'h00 -> chr_addr=17'h03234.
- ctrl mirroring=2'b11 with ppu_addr=14'h2C00 -> ciram_ce=1, ciram_a10=1. With prg=5'h10 and a $6000 access -> prgram_cs=0.
